// File: rtl/rom_pkg.sv
// Shared definitions for the parity-protected ROM and its scan controller.
//   AW    : ROM address width
//   DW    : data width, parity bit excluded
//   DEPTH : number of ROM entries
//   SUMW  : width of the scan data sum; must hold DEPTH * (2**DW - 1)
//   state_t : scan controller FSM encoding
package rom_pkg;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int SUMW  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even parity: the stored bit equals the XOR of the data bits.
  function automatic logic even_par_good(input logic [DW-1:0] num, input logic par);
    return (^num) == par;
  endfunction

endpackage

// File: rtl/parity_chk.sv
// Even-parity checker for one ROM word.
//   num  in  DW  data bits
//   par  in  1   stored parity bit
//   good out 1   1 when the XOR of num matches par
module parity_chk #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] num,
  input  logic          par,
  output logic          good
);

  assign good = ((^num) == par);

endmodule

// File: rtl/parity_scan_ctrl.sv
// Scan sequencer and address-port arbiter for the parity-protected ROM.
// A start pulse walks every ROM entry, counting parity failures, latching the
// lowest failing address and summing the data. External single reads share
// the ROM address port and always win; they stall the scan for one cycle each.
//   clk, reset          clock, synchronous active-high reset
//   start               begins a scan when idle
//   req, req_addr       external single read
//   mem_addr            ROM address (combinational)
//   mem_num, mem_par    ROM data and stored parity, same cycle as mem_addr
//   ack, rdata, rpar_ok registered read response, one cycle after req
//   busy, done          scan in progress / one-cycle completion pulse
//   err_count, err_flag, first_err_addr, sum   results of the last scan
module parity_scan_ctrl
  import rom_pkg::*;
#(
  parameter int AW   = rom_pkg::AW,
  parameter int DW   = rom_pkg::DW,
  parameter int SUMW = rom_pkg::SUMW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            req,
  input  logic [AW-1:0]   req_addr,
  output logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_num,
  input  logic            mem_par,
  output logic            ack,
  output logic [DW-1:0]   rdata,
  output logic            rpar_ok,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     err_count,
  output logic            err_flag,
  output logic [AW-1:0]   first_err_addr,
  output logic [SUMW-1:0] sum
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state;
  logic [AW-1:0] scan_ptr;
  logic          good;

  // Requests take the port unconditionally; the scan only sees the ROM on
  // cycles with no request.
  assign mem_addr = req ? req_addr : scan_ptr;

  // One checker serves both paths since they see the same muxed ROM word.
  parity_chk #(.DW(DW)) u_chk (
    .num  (mem_num),
    .par  (mem_par),
    .good (good)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      scan_ptr       <= '0;
      ack            <= 1'b0;
      rdata          <= '0;
      rpar_ok        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
      sum            <= '0;
    end else begin
      // Read port: served every cycle it is asked, regardless of FSM state.
      ack <= req;
      if (req) begin
        rdata   <= mem_num;
        rpar_ok <= good;
      end

      done <= 1'b0;

      case (state)
        IDLE: begin
          scan_ptr <= '0;
          if (start) begin
            state          <= SCAN;
            busy           <= 1'b1;
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
            sum            <= '0;
          end
        end

        SCAN: begin
          if (!req) begin
            sum <= sum + SUMW'(mem_num);
            if (!good) begin
              err_count <= err_count + 1'b1;
              err_flag  <= 1'b1;
              // err_count still holds the pre-increment value here, so zero
              // marks the first failure of this scan.
              if (err_count == '0)
                first_err_addr <= scan_ptr;
            end
            scan_ptr <= scan_ptr + 1'b1;
            if (scan_ptr == LAST_ADDR) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          scan_ptr <= '0;
        end

        default: begin
          state    <= IDLE;
          scan_ptr <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Directed bench for parity_scan_ctrl with a behavioural 8x9 ROM.
// Note on the ROM contents: 8'h1B = 0001_1011 has four ones, so under even
// parity its correct stored bit is 0 (good) and 1 is a failing entry.
// 8'h30 has two ones, so par 0 is good.
module tb_parity_scan_ctrl;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int SUMW = 11;

  logic            clk = 1'b0;
  logic            reset, start, req;
  logic [AW-1:0]   req_addr, mem_addr;
  logic [DW-1:0]   mem_num;
  logic            mem_par;
  logic            ack, rpar_ok, busy, done, err_flag;
  logic [DW-1:0]   rdata;
  logic [AW:0]     err_count;
  logic [AW-1:0]   first_err_addr;
  logic [SUMW-1:0] sum;

  logic [DW-1:0] rom_num [8];
  logic          rom_par [8];

  int checks   = 0;
  int failures = 0;

  // Per-run measurements from run_scan
  int busy_n, done_n, done_k;

  always #5 clk = ~clk;

  assign mem_num = rom_num[mem_addr];
  assign mem_par = rom_par[mem_addr];

  parity_scan_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .req            (req),
    .req_addr       (req_addr),
    .mem_addr       (mem_addr),
    .mem_num        (mem_num),
    .mem_par        (mem_par),
    .ack            (ack),
    .rdata          (rdata),
    .rpar_ok        (rpar_ok),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .err_flag       (err_flag),
    .first_err_addr (first_err_addr),
    .sum            (sum)
  );

  // Pulses start (with optional req bit 0 in the same cycle), then runs 24
  // cycles. Cycle k is the k-th cycle after the edge that sampled start.
  // req_mask bit k drives req during cycle k; again_k re-pulses start and
  // rst_k pulses reset in that cycle (0 = never).
  task automatic run_scan(input logic [23:0] req_mask, input logic [AW-1:0] raddr,
                          input logic [DW-1:0] exp_rdata, input logic exp_rok,
                          input int again_k, input int rst_k);
    logic prev_req;
    busy_n = 0; done_n = 0; done_k = 0;
    @(negedge clk);
    start = 1'b1; req = req_mask[0]; req_addr = raddr; prev_req = req_mask[0];
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      checks++;
      if (ack !== prev_req) begin
        failures++;
        $display("FAIL ack_cycle%0d got=%b exp=%b", k, ack, prev_req);
      end
      if (prev_req) begin
        checks++;
        if ({rdata, rpar_ok} !== {exp_rdata, exp_rok}) begin
          failures++;
          $display("FAIL rdata_cycle%0d got=%h/%b exp=%h/%b", k, rdata, rpar_ok, exp_rdata, exp_rok);
        end
      end
      req      = (k < 24) ? req_mask[k] : 1'b0;
      prev_req = req;
      start    = (k == again_k);
      reset    = (k == rst_k);
      @(negedge clk);
    end
    req = 1'b0; start = 1'b0; reset = 1'b0;
  endtask

  task automatic set_rom_good;
    for (int i = 0; i < 8; i++) begin
      rom_num[i] = 8'h1B; rom_par[i] = 1'b0;
    end
  endtask

  task automatic set_rom_model;
    for (int i = 0; i < 8; i++) begin
      rom_num[i] = 8'h1B; rom_par[i] = 1'b1;
    end
    rom_num[1] = 8'h30; rom_par[1] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; req = 1'b0; req_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, rdata, rpar_ok, busy, done, err_count, err_flag, first_err_addr, sum, mem_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b rdata=%h rok=%b busy=%b done=%b cnt=%0d flag=%b first=%0d sum=%0d addr=%0d exp all 0",
               ack, rdata, rpar_ok, busy, done, err_count, err_flag, first_err_addr, sum, mem_addr);
    end
  endtask

  task automatic test_all_good;
    set_rom_good();
    run_scan(24'h0, 3'd0, 8'h00, 1'b0, 0, 0);
    checks++;
    if ({busy_n, done_n, done_k} !== {32'd8, 32'd1, 32'd9}) begin
      failures++;
      $display("FAIL good_timing got busy=%0d done_n=%0d done_k=%0d exp 8/1/9", busy_n, done_n, done_k);
    end
    checks++;
    if ({err_count, err_flag, first_err_addr, sum} !== {4'd0, 1'b0, 3'd0, 11'd216}) begin
      failures++;
      $display("FAIL good_results got cnt=%0d flag=%b first=%0d sum=%0d exp 0/0/0/216", err_count, err_flag, first_err_addr, sum);
    end
  endtask

  task automatic test_errors;
    set_rom_model();
    run_scan(24'h0, 3'd0, 8'h00, 1'b0, 0, 0);
    checks++;
    if ({busy_n, done_n, done_k} !== {32'd8, 32'd1, 32'd9}) begin
      failures++;
      $display("FAIL err_timing got busy=%0d done_n=%0d done_k=%0d exp 8/1/9", busy_n, done_n, done_k);
    end
    checks++;
    if ({err_count, err_flag, first_err_addr, sum} !== {4'd7, 1'b1, 3'd0, 11'd237}) begin
      failures++;
      $display("FAIL err_results got cnt=%0d flag=%b first=%0d sum=%0d exp 7/1/0/237", err_count, err_flag, first_err_addr, sum);
    end
  endtask

  task automatic test_first_err;
    set_rom_model();
    rom_par[0] = 1'b0;
    run_scan(24'h0, 3'd0, 8'h00, 1'b0, 0, 0);
    checks++;
    if ({err_count, err_flag, first_err_addr, sum} !== {4'd6, 1'b1, 3'd2, 11'd237}) begin
      failures++;
      $display("FAIL first_err got cnt=%0d flag=%b first=%0d sum=%0d exp 6/1/2/237", err_count, err_flag, first_err_addr, sum);
    end
  endtask

  task automatic test_mid_req;
    // Same ROM as test_first_err; reads of addr 1 in cycles 3,4,5.
    run_scan(24'h38, 3'd1, 8'h30, 1'b1, 0, 0);
    checks++;
    if ({busy_n, done_n, done_k} !== {32'd11, 32'd1, 32'd12}) begin
      failures++;
      $display("FAIL midreq_timing got busy=%0d done_n=%0d done_k=%0d exp 11/1/12", busy_n, done_n, done_k);
    end
    checks++;
    if ({err_count, err_flag, first_err_addr, sum} !== {4'd6, 1'b1, 3'd2, 11'd237}) begin
      failures++;
      $display("FAIL midreq_results got cnt=%0d flag=%b first=%0d sum=%0d exp 6/1/2/237", err_count, err_flag, first_err_addr, sum);
    end
  endtask

  task automatic test_start_with_req;
    // Read of addr 2 (0x1B with par 1: failing) in the same cycle as start.
    run_scan(24'h1, 3'd2, 8'h1B, 1'b0, 0, 0);
    checks++;
    if ({busy_n, done_n, done_k} !== {32'd8, 32'd1, 32'd9}) begin
      failures++;
      $display("FAIL startreq_timing got busy=%0d done_n=%0d done_k=%0d exp 8/1/9", busy_n, done_n, done_k);
    end
    checks++;
    if ({err_count, first_err_addr, sum} !== {4'd6, 3'd2, 11'd237}) begin
      failures++;
      $display("FAIL startreq_results got cnt=%0d first=%0d sum=%0d exp 6/2/237", err_count, first_err_addr, sum);
    end
  endtask

  task automatic test_start_ignored;
    set_rom_good();
    run_scan(24'h0, 3'd0, 8'h00, 1'b0, 3, 0);
    checks++;
    if ({busy_n, done_n, done_k} !== {32'd8, 32'd1, 32'd9}) begin
      failures++;
      $display("FAIL start_busy got busy=%0d done_n=%0d done_k=%0d exp 8/1/9", busy_n, done_n, done_k);
    end
    // start while in DONE (cycle 9) is ignored as well
    run_scan(24'h0, 3'd0, 8'h00, 1'b0, 9, 0);
    checks++;
    if ({busy_n, done_n, done_k} !== {32'd8, 32'd1, 32'd9}) begin
      failures++;
      $display("FAIL start_done got busy=%0d done_n=%0d done_k=%0d exp 8/1/9", busy_n, done_n, done_k);
    end
    checks++;
    if ({err_count, err_flag, sum} !== {4'd0, 1'b0, 11'd216}) begin
      failures++;
      $display("FAIL start_ign_results got cnt=%0d flag=%b sum=%0d exp 0/0/216", err_count, err_flag, sum);
    end
  endtask

  task automatic test_reset_mid;
    set_rom_model();
    run_scan(24'h0, 3'd0, 8'h00, 1'b0, 0, 4);
    checks++;
    if ({busy_n, done_n} !== {32'd4, 32'd0}) begin
      failures++;
      $display("FAIL rstmid_timing got busy=%0d done_n=%0d exp 4/0", busy_n, done_n);
    end
    checks++;
    if ({err_count, err_flag, first_err_addr, sum, mem_addr, busy} !== '0) begin
      failures++;
      $display("FAIL rstmid_results got cnt=%0d flag=%b first=%0d sum=%0d addr=%0d busy=%b exp all 0",
               err_count, err_flag, first_err_addr, sum, mem_addr, busy);
    end
  endtask

  initial begin
    set_rom_good();
    test_reset();
    test_all_good();
    test_errors();
    test_first_err();
    test_mid_req();
    test_start_with_req();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
